// File: rtl/out_uart_tx_if.sv
// Console bus between the CPU output register and the UART transmitter.
//   sys_out : CPU output register value, synchronous to the system clock
//   uart_tx : serial line, idle high
//   busy    : high while a frame is being shifted out
//   overrun : one-cycle pulse when a pending value is replaced before being sent
// master = CPU side (drives sys_out), slave = transmitter side.
interface out_uart_tx_if;
  logic [15:0] sys_out;
  logic        uart_tx;
  logic        busy;
  logic        overrun;

  modport master (
    output sys_out,
    input  uart_tx,
    input  busy,
    input  overrun
  );

  modport slave (
    input  sys_out,
    output uart_tx,
    output busy,
    output overrun
  );
endinterface

// File: rtl/out_uart_tx.sv
// Serial console driver for the CPU output register.
// Every change of sys_out is sent as four uppercase ASCII hex digits followed by CR LF on an
// 8N1 line (LSB first). A single-entry overwrite buffer keeps the newest value while a frame is
// in flight; replacing an unsent value pulses overrun.
// Ports:
//   clk  : system clock, all state changes on the rising edge
//   arst : asynchronous reset, active-high
//   bus  : out_uart_tx_if.slave (sys_out in; uart_tx, busy, overrun out, all registered)
module out_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868  // legal range 2..65535
) (
  input logic          clk,
  input logic          arst,
  out_uart_tx_if.slave bus
);

  localparam int unsigned     CntW     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] BaudMax  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      LastChar = 3'd5;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q;
  logic [15:0]     sys_q;
  logic [15:0]     pending_val_q;
  logic            pending_q;
  logic [15:0]     frame_val_q;
  logic [CntW-1:0] baud_q;
  logic [2:0]      bit_idx_q;
  logic [2:0]      char_idx_q;
  logic            tx_q;
  logic            busy_q;
  logic            overrun_q;

  logic       change;
  logic       bit_end;
  logic       consume;
  logic [2:0] next_bit;
  logic [3:0] nibble;
  logic [7:0] char_byte;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  always_comb begin
    change   = (bus.sys_out != sys_q);
    bit_end  = (baud_q == BaudMax);
    // The pending slot is read on this edge: either a frame starts from idle, or the last
    // stop bit of a frame ends and a back-to-back frame begins.
    consume  = pending_q && ((state_q == StIdle) ||
                             ((state_q == StStop) && bit_end && (char_idx_q == LastChar)));
    next_bit = bit_idx_q + 3'd1;

    nibble = 4'h0;
    case (char_idx_q)
      3'd0:    nibble = frame_val_q[15:12];
      3'd1:    nibble = frame_val_q[11:8];
      3'd2:    nibble = frame_val_q[7:4];
      3'd3:    nibble = frame_val_q[3:0];
      default: nibble = 4'h0;
    endcase

    char_byte = hex_ascii(nibble);
    if (char_idx_q == 3'd4) begin
      char_byte = 8'h0D;
    end else if (char_idx_q == LastChar) begin
      char_byte = 8'h0A;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q       <= StIdle;
      sys_q         <= 16'h0000;
      pending_val_q <= 16'h0000;
      pending_q     <= 1'b0;
      frame_val_q   <= 16'h0000;
      baud_q        <= '0;
      bit_idx_q     <= 3'd0;
      char_idx_q    <= 3'd0;
      tx_q          <= 1'b1;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      sys_q     <= bus.sys_out;
      overrun_q <= 1'b0;

      // A change always wins the slot; if the slot is read on the same edge the old value goes
      // into the frame and the new one stays pending, so nothing is lost.
      if (change) begin
        pending_val_q <= bus.sys_out;
        pending_q     <= 1'b1;
        overrun_q     <= pending_q && !consume;
      end else if (consume) begin
        pending_q <= 1'b0;
      end

      if (state_q != StIdle) begin
        baud_q <= bit_end ? '0 : baud_q + CntW'(1);
      end

      unique case (state_q)
        StIdle: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          baud_q <= '0;
          if (pending_q) begin
            state_q     <= StStart;
            frame_val_q <= pending_val_q;
            char_idx_q  <= 3'd0;
            tx_q        <= 1'b0;
            busy_q      <= 1'b1;
          end
        end

        StStart: begin
          if (bit_end) begin
            state_q   <= StData;
            bit_idx_q <= 3'd0;
            tx_q      <= char_byte[0];
          end
        end

        StData: begin
          if (bit_end) begin
            if (bit_idx_q == 3'd7) begin
              state_q <= StStop;
              tx_q    <= 1'b1;
            end else begin
              bit_idx_q <= next_bit;
              tx_q      <= char_byte[next_bit];
            end
          end
        end

        StStop: begin
          if (bit_end) begin
            if (char_idx_q != LastChar) begin
              state_q    <= StStart;
              char_idx_q <= char_idx_q + 3'd1;
              tx_q       <= 1'b0;
            end else if (pending_q) begin
              state_q     <= StStart;
              frame_val_q <= pending_val_q;
              char_idx_q  <= 3'd0;
              tx_q        <= 1'b0;
            end else begin
              state_q <= StIdle;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign bus.uart_tx = tx_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_out_uart_tx.sv
// Bench for out_uart_tx: three instances (CLKS_PER_BIT = 4, 2, 868). Line, busy and overrun of
// the selected instance are recorded once per cycle on the falling edge and compared with the
// ideal 8N1 waveform of the expected hex+CRLF text.
module tb_out_uart_tx;

  logic clk  = 1'b0;
  logic arst = 1'b1;

  always #5 clk = ~clk;

  out_uart_tx_if bus4 ();
  out_uart_tx_if bus2 ();
  out_uart_tx_if bus868 ();

  out_uart_tx #(.CLKS_PER_BIT(4)) u_dut4 (
    .clk  (clk),
    .arst (arst),
    .bus  (bus4)
  );

  out_uart_tx #(.CLKS_PER_BIT(2)) u_dut2 (
    .clk  (clk),
    .arst (arst),
    .bus  (bus2)
  );

  out_uart_tx #(.CLKS_PER_BIT(868)) u_dut868 (
    .clk  (clk),
    .arst (arst),
    .bus  (bus868)
  );

  logic [2:0] tx_all;
  logic [2:0] busy_all;
  logic [2:0] ovr_all;
  assign tx_all   = {bus868.uart_tx, bus2.uart_tx, bus4.uart_tx};
  assign busy_all = {bus868.busy, bus2.busy, bus4.busy};
  assign ovr_all  = {bus868.overrun, bus2.overrun, bus4.overrun};

  int   n_checks = 0;
  int   n_fail   = 0;
  int   rec_sel  = 0;
  logic rec_en   = 1'b0;
  logic tr_tx[$];
  logic tr_busy[$];
  logic tr_ovr[$];

  always @(negedge clk) begin
    if (rec_en) begin
      tr_tx.push_back(tx_all[rec_sel]);
      tr_busy.push_back(busy_all[rec_sel]);
      tr_ovr.push_back(ovr_all[rec_sel]);
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Leaves the bench one delta past a rising edge, where inputs are driven.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic [15:0] v);
    case (sel)
      0:       bus4.sys_out = v;
      1:       bus2.sys_out = v;
      default: bus868.sys_out = v;
    endcase
  endtask

  task automatic rec_start(input int sel);
    tr_tx.delete();
    tr_busy.delete();
    tr_ovr.delete();
    rec_sel = sel;
    rec_en  = 1'b1;
  endtask

  // Reference model: the text of one frame and the ideal line level at each cycle of it.
  function automatic logic [7:0] exp_char(input logic [15:0] v, input int i);
    int n;
    if (i == 4) return 8'h0D;
    if (i == 5) return 8'h0A;
    n = (int'(v) >> (12 - 4 * i)) % 16;
    return (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);  // '0'.. or 'A'..
  endfunction

  function automatic logic exp_level(input logic [15:0] v, input int t, input int cpb);
    int         bitpos;
    int         b;
    logic [7:0] c;
    bitpos = t / cpb;
    b      = bitpos % 10;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    c = exp_char(v, bitpos / 10);
    return c[b-1];
  endfunction

  function automatic int find_start(input int from);
    for (int i = from; i < tr_tx.size(); i++) begin
      if (tr_tx[i] == 1'b0) return i;
    end
    return -1;
  endfunction

  function automatic int count_hi(input int which, input int lo, input int hi);
    int cnt = 0;
    for (int i = (lo < 0 ? 0 : lo); i < hi && i < tr_tx.size(); i++) begin
      case (which)
        0:       cnt += int'(tr_tx[i]);
        1:       cnt += int'(tr_busy[i]);
        default: cnt += int'(tr_ovr[i]);
      endcase
    end
    return cnt;
  endfunction

  task automatic check_frame(input string tag, input int s, input int cpb, input logic [15:0] v);
    int         mism;
    logic [7:0] got;
    logic       in_span;
    in_span = (s >= 0) && (s + 60 * cpb <= tr_tx.size());
    check_eq({tag, ".span"}, int'(in_span), 1);
    if (in_span) begin
      for (int i = 0; i < 6; i++) begin
        for (int b = 0; b < 8; b++) begin
          got[b] = tr_tx[s + (i * 10 + 1 + b) * cpb + cpb / 2];
        end
        check_eq($sformatf("%s.chr%0d", tag, i), int'(got), int'(exp_char(v, i)));
      end
      mism = 0;
      for (int t = 0; t < 60 * cpb; t++) begin
        if (tr_tx[s + t] !== exp_level(v, t, cpb)) mism++;
      end
      check_eq({tag, ".wave"}, mism, 0);
    end
  endtask

  function automatic logic [15:0] rand_diff(input logic [15:0] old);
    logic [15:0] v;
    v = 16'($urandom);
    if (v == old) v = ~old;
    return v;
  endfunction

  initial begin
    int          c;
    int          c3;
    int          s;
    int          w;
    int          nw;
    logic [15:0] cur;
    logic [15:0] v;
    logic [15:0] v2;

    bus4.sys_out   = 16'h0000;
    bus2.sys_out   = 16'h0000;
    bus868.sys_out = 16'h0000;

    // Reset state
    tick(3);
    check_eq("reset.tx", int'(bus4.uart_tx), 1);
    check_eq("reset.busy", int'(bus4.busy), 0);
    check_eq("reset.overrun", int'(bus4.overrun), 0);
    arst = 1'b0;

    // Idle after reset: SYS_OUT stays at its reset value
    rec_start(0);
    tick(1000);
    rec_en = 1'b0;
    check_eq("idle.tx_high", count_hi(0, 0, tr_tx.size()), tr_tx.size());
    check_eq("idle.busy", count_hi(1, 0, tr_tx.size()), 0);

    // Single value
    rec_start(0);
    c = tr_tx.size();
    drive(0, 16'h1A2F);
    tick(270);
    rec_en = 1'b0;
    s = find_start(c);
    check_eq("single.latency", s - c, 2);
    check_frame("single", s, 4, 16'h1A2F);
    check_eq("single.busy_total", count_hi(1, 0, tr_tx.size()), 240);
    check_eq("single.busy_span", count_hi(1, s, s + 240), 240);
    check_eq("single.overrun", count_hi(2, 0, tr_tx.size()), 0);

    // Overwrite: 0x0002 fills the slot, 0x0003 replaces it
    rec_start(0);
    c = tr_tx.size();
    drive(0, 16'h0001);
    tick(20);
    drive(0, 16'h0002);
    tick(20);
    c3 = tr_tx.size();
    drive(0, 16'h0003);
    tick(520);
    rec_en = 1'b0;
    s = find_start(c);
    check_eq("ovw.latency", s - c, 2);
    check_frame("ovw.f1", s, 4, 16'h0001);
    check_frame("ovw.f2", s + 240, 4, 16'h0003);
    check_eq("ovw.overrun_count", count_hi(2, 0, tr_ovr.size()), 1);
    check_eq("ovw.overrun_at", count_hi(2, c3 + 1, c3 + 2), 1);
    check_eq("ovw.busy_span", count_hi(1, s, s + 480), 480);
    check_eq("ovw.busy_total", count_hi(1, 0, tr_busy.size()), 480);
    cur = 16'h0003;

    // Randomized: one value, then a burst of 0..3 one-cycle writes during its frame
    for (int it = 0; it < 4; it++) begin
      rec_start(0);
      c = tr_tx.size();
      v = rand_diff(cur);
      drive(0, v);
      cur = v;
      w  = $urandom_range(5, 200);
      nw = $urandom_range(0, 3);
      tick(w);
      for (int k = 0; k < nw; k++) begin
        cur = rand_diff(cur);
        drive(0, cur);
        tick(1);
      end
      tick(520 - w - nw);
      rec_en = 1'b0;
      s = find_start(c);
      check_eq($sformatf("rnd%0d.latency", it), s - c, 2);
      check_frame($sformatf("rnd%0d.f1", it), s, 4, v);
      check_eq($sformatf("rnd%0d.overrun", it), count_hi(2, 0, tr_ovr.size()),
               (nw > 1) ? nw - 1 : 0);
      if (nw > 0) begin
        check_frame($sformatf("rnd%0d.f2", it), s + 240, 4, cur);
        check_eq($sformatf("rnd%0d.busy", it), count_hi(1, 0, tr_busy.size()), 480);
      end else begin
        check_eq($sformatf("rnd%0d.busy", it), count_hi(1, 0, tr_busy.size()), 240);
      end
    end

    // Reset mid-frame, during the start bit of char 2
    rec_start(0);
    c = tr_tx.size();
    drive(0, 16'hBEEF);
    tick(83);
    s = find_start(c);
    check_eq("rst.latency", s - c, 2);
    check_eq("rst.pre_tx", int'(bus4.uart_tx), 0);
    check_eq("rst.pre_busy", int'(bus4.busy), 1);
    arst = 1'b1;
    drive(0, 16'h0000);  // the CPU output register clears on the same reset
    #1;
    check_eq("rst.async_tx", int'(bus4.uart_tx), 1);
    check_eq("rst.async_busy", int'(bus4.busy), 0);
    tick(3);
    arst = 1'b0;
    rec_start(0);
    tick(300);
    check_eq("rst.quiet_tx", count_hi(0, 0, tr_tx.size()), tr_tx.size());
    check_eq("rst.quiet_busy", count_hi(1, 0, tr_busy.size()), 0);
    c = tr_tx.size();
    drive(0, 16'h00FF);
    tick(260);
    rec_en = 1'b0;
    s = find_start(c);
    check_eq("rst.after_latency", s - c, 2);
    check_frame("rst.after", s, 4, 16'h00FF);
    cur = 16'h00FF;

    // Same-edge capture: second change lands on the IDLE -> START edge
    v  = rand_diff(cur);
    v2 = rand_diff(v);
    rec_start(0);
    c = tr_tx.size();
    drive(0, v);
    tick(1);
    drive(0, v2);
    tick(520);
    rec_en = 1'b0;
    s = find_start(c);
    check_eq("same.latency", s - c, 2);
    check_frame("same.f1", s, 4, v);
    check_frame("same.f2", s + 240, 4, v2);
    check_eq("same.overrun", count_hi(2, 0, tr_ovr.size()), 0);
    check_eq("same.busy", count_hi(1, s, s + 480), 480);

    // Timing sweep, CLKS_PER_BIT = 2
    rec_start(1);
    c = tr_tx.size();
    drive(1, 16'hFFFF);
    tick(140);
    rec_en = 1'b0;
    s = find_start(c);
    check_eq("cpb2.latency", s - c, 2);
    check_frame("cpb2", s, 2, 16'hFFFF);
    check_eq("cpb2.busy", count_hi(1, 0, tr_busy.size()), 120);

    // Timing sweep, CLKS_PER_BIT = 868
    rec_start(2);
    c = tr_tx.size();
    drive(2, 16'hFFFF);
    tick(60 * 868 + 20);
    rec_en = 1'b0;
    s = find_start(c);
    check_eq("cpb868.latency", s - c, 2);
    check_frame("cpb868", s, 868, 16'hFFFF);
    check_eq("cpb868.busy", count_hi(1, 0, tr_busy.size()), 60 * 868);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
